// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
//
// Single-clock FIFO that buffers a write stream for in-order retrieval by a
// reader in the same clock domain. Storage is a plain array, written
// synchronously and read into a register, so it maps onto block RAM.
// Overflow (write while full) and underflow (read while empty) are reported
// as one-cycle pulses. The offending request is ignored and state is not
// corrupted.
//
// Parameters
//   DATA_WIDTH      width of data_in/data_out and of each storage word
//   ADDR_WIDTH      storage address width, DEPTH = 2**ADDR_WIDTH
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst_n           asynchronous active-low reset (storage is not cleared)
//   wr              write request, data_in captured when not full
//   rd              read request, data_out updated when not empty
//   data_in         write data
//   data_out        registered read data, holds value when no read occurs
//   fifo_full       DEPTH entries stored
//   fifo_empty      no entries stored
//   fifo_overflow   one-cycle pulse: wr seen while full (write dropped)
//   fifo_underflow  one-cycle pulse: rd seen while empty (read ignored)
// ---------------------------------------------------------------------------
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so that full and empty can be told
  // apart when the low (storage index) bits are equal.
  logic [ADDR_WIDTH:0]   wr_ptr_reg;
  logic [ADDR_WIDTH:0]   rd_ptr_reg;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic wr_en;
  logic rd_en;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                      (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);

  // Accept decisions use the flags as they stood before the edge. On full,
  // a simultaneous read does not make room for the write in the same cycle.
  assign wr_en = wr & ~fifo_full;
  assign rd_en = rd & ~fifo_empty;

  // Storage has no reset so it can be inferred as block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      data_out       <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      // A read never addresses the slot being written in the same cycle:
      // equal indices mean either empty (no read) or full (no write).
      if (rd_en) begin
        data_out   <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      fifo_overflow  <= wr & fifo_full;
      fifo_underflow <= rd & fifo_empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_mem
//
// Scoreboard bench for sync_fifo_mem. The driver applies one request per
// cycle on the falling edge. It steps a queue-based reference FIFO and
// pushes the expected post-edge outputs into exp_q. A separate monitor pops
// one entry after every rising edge and compares all outputs.
// ---------------------------------------------------------------------------
module tb_sync_fifo_mem;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          wr;
  logic          rd;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_overflow;
  logic          fifo_underflow;

  sync_fifo_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr             (wr),
    .rd             (rd),
    .data_in        (data_in),
    .data_out       (data_out),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow)
  );

  typedef struct {
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
    string         tag;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_q[$];   // reference FIFO contents
  logic [DW-1:0] model_out;    // last value the reader should see
  int            n_checks;
  int            n_errors;

  // Clock starts late so the initial reset can be checked with no edge.
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One request per cycle: drive on the falling edge and queue the expected
  // result of the following rising edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    exp_t e;
    bit   was_full;
    bit   was_empty;
    @(negedge clk);
    wr      = w;
    rd      = r;
    data_in = d;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (r && !was_empty) model_out = model_q.pop_front();
    if (w && !was_full)  model_q.push_back(d);
    e.dout  = model_out;
    e.full  = (model_q.size() == DEPTH);
    e.empty = (model_q.size() == 0);
    e.ovf   = w & was_full;
    e.unf   = r & was_empty;
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry is consumed per rising edge, sampled 1 time
  // unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".data_out"}, 32'(data_out),       32'(e.dout));
        check({e.tag, ".full"},     32'(fifo_full),      32'(e.full));
        check({e.tag, ".empty"},    32'(fifo_empty),     32'(e.empty));
        check({e.tag, ".overflow"}, 32'(fifo_overflow),  32'(e.ovf));
        check({e.tag, ".underflow"},32'(fifo_underflow), 32'(e.unf));
        $display("txn %-6s wr=%0b rd=%0b dout=%02h full=%0b empty=%0b ovf=%0b unf=%0b",
                 e.tag, wr, rd, data_out, fifo_full, fifo_empty, fifo_overflow, fifo_underflow);
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    n_checks  = 0;
    n_errors  = 0;
    wr        = 1'b0;
    rd        = 1'b0;
    data_in   = '0;
    model_out = '0;
    rst_n     = 1'b1;

    // Reset without any clock edge.
    #5 rst_n = 1'b0;
    #1;
    check("reset.empty",    32'(fifo_empty),     32'd1);
    check("reset.full",     32'(fifo_full),      32'd0);
    check("reset.data_out", 32'(data_out),       32'h00);
    check("reset.overflow", 32'(fifo_overflow),  32'd0);
    check("reset.underflow",32'(fifo_underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with 1..16, then a dropped 17th write.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i), "fill");
    step(1'b1, 1'b0, 8'd99, "ovf");
    step(1'b0, 1'b0, 8'h00, "idle");

    // Drain, then an ignored read while empty.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, "drain");
    step(1'b0, 1'b1, 8'h00, "unf");
    step(1'b0, 1'b0, 8'h00, "idle");

    // Simultaneous read/write at occupancy 5 across the pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom), "pre5");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'($urandom), "rdwr");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "post5");

    // Reset asserted with 8 entries held.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(8'h40 + i), "pre8");
    @(negedge clk);
    wr    = 1'b0;
    rd    = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst.empty",    32'(fifo_empty), 32'd1);
    check("midrst.full",     32'(fifo_full),  32'd0);
    check("midrst.data_out", 32'(data_out),   32'h00);
    model_q.delete();
    model_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hA5, "postwr");
    step(1'b0, 1'b1, 8'h00, "postrd");
    step(1'b0, 1'b0, 8'h00, "idle");

    // Random traffic, biased both ways to reach full and empty repeatedly.
    for (int i = 0; i < 300; i++) begin
      d = DW'($urandom);
      if (i < 150) step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4), d, "rnd");
      else         step(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 7), d, "rnd");
    end
    step(1'b0, 1'b0, 8'h00, "idle");

    // Let the monitor consume the remaining entries (bounded wait).
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard.drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
